// File: rtl/mem_access_unit_if.sv
// Data-memory request/acknowledge bus between the MEM-stage load/store engine
// (master) and the data memory (slave).
interface mem_access_unit_if;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;

    modport master (
        output dm_req, dm_we, dm_addr, dm_be, dm_wdata,
        input  dm_rdata, dm_ack
    );

    modport slave (
        input  dm_req, dm_we, dm_addr, dm_be, dm_wdata,
        output dm_rdata, dm_ack
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: issues one req/ack bus transaction per access,
// stalls the pipeline while it is outstanding and returns extended load data.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_data,
    input  logic [1:0]        mem_ctrl,
    input  logic [1:0]        mem_op,
    input  logic              mem_uns,
    input  logic              flush,
    input  logic              stage_en,
    mem_access_unit_if.master dm,
    output logic              mem_stall,
    output logic [31:0]       load_data,
    output logic              load_valid,
    output logic              adel,
    output logic              ades,
    output logic              bus_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nx;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_aligned;
    logic        w_acc;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic        w_issue;
    logic        w_ack;
    logic        w_timeout;
    logic        w_drop;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ext;

    logic             r_req;
    logic             r_we;
    logic [31:0]      r_addr;
    logic [3:0]       r_be;
    logic [31:0]      r_wdata;
    logic [1:0]       r_op;
    logic             r_uns;
    logic [1:0]       r_lane;
    logic [CNT_W-1:0] r_cnt;
    logic             r_drop;
    logic [31:0]      r_load_data;
    logic             r_load_valid;
    logic             r_bus_err;

    // Request decode: alignment, byte enables and lane-replicated store data.
    always_comb begin
        w_is_store = (mem_ctrl == 2'b01);
        w_is_load  = (mem_ctrl == 2'b10);
        w_aligned  = 1'b1;
        w_be       = 4'b0000;
        w_wdata    = '0;
        case (mem_op)
            2'b00: begin
                w_aligned = (mem_addr[1:0] == 2'b00);
                w_be      = 4'b1111;
                w_wdata   = mem_data;
            end
            2'b01: begin
                w_aligned = ~mem_addr[0];
                w_be      = mem_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata   = {2{mem_data[15:0]}};
            end
            default: begin
                w_aligned = 1'b1;
                w_be      = 4'b0001 << mem_addr[1:0];
                w_wdata   = {4{mem_data[7:0]}};
            end
        endcase
        w_acc = (w_is_load | w_is_store) & w_aligned & ~flush;
    end

    assign adel = w_is_load  & ~w_aligned & ~flush;
    assign ades = w_is_store & ~w_aligned & ~flush;

    // Lane select and extension use the context latched at issue, not the live inputs.
    always_comb begin
        w_byte = '0;
        case (r_lane)
            2'd0:    w_byte = dm.dm_rdata[7:0];
            2'd1:    w_byte = dm.dm_rdata[15:8];
            2'd2:    w_byte = dm.dm_rdata[23:16];
            default: w_byte = dm.dm_rdata[31:24];
        endcase
        w_half = r_lane[1] ? dm.dm_rdata[31:16] : dm.dm_rdata[15:0];
        w_ext  = dm.dm_rdata;
        case (r_op)
            2'b00:   w_ext = dm.dm_rdata;
            2'b01:   w_ext = {{16{w_half[15] & ~r_uns}}, w_half};
            default: w_ext = {{24{w_byte[7] & ~r_uns}}, w_byte};
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        mem_stall  = 1'b0;
        w_issue    = 1'b0;
        w_ack      = 1'b0;
        w_timeout  = 1'b0;
        w_drop     = r_drop;
        case (r_state)
            S_IDLE: begin
                mem_stall = w_acc;
                if (w_acc) begin
                    w_issue    = 1'b1;
                    w_state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                mem_stall = 1'b1;
                w_ack     = dm.dm_ack;
                w_timeout = ~dm.dm_ack & (r_cnt == CNT_W'(TIMEOUT));
                // A flush arriving in the completing cycle still drops the result.
                w_drop    = r_drop | flush;
                if (w_ack | w_timeout) begin
                    w_state_nx = w_drop ? S_IDLE : S_DONE;
                end
            end
            S_DONE: begin
                if (stage_en) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_req        <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_be         <= '0;
            r_wdata      <= '0;
            r_op         <= '0;
            r_uns        <= 1'b0;
            r_lane       <= '0;
            r_cnt        <= '0;
            r_drop       <= 1'b0;
            r_load_data  <= '0;
            r_load_valid <= 1'b0;
            r_bus_err    <= 1'b0;
        end else begin
            if (w_issue) begin
                r_req   <= 1'b1;
                r_we    <= w_is_store;
                r_addr  <= {mem_addr[31:2], 2'b00};
                r_be    <= w_be;
                r_wdata <= w_wdata;
                r_op    <= mem_op;
                r_uns   <= mem_uns;
                r_lane  <= mem_addr[1:0];
                r_cnt   <= '0;
                r_drop  <= 1'b0;
            end
            if (r_state == S_WAIT) begin
                r_cnt  <= r_cnt + CNT_W'(1);
                r_drop <= w_drop;
                if (w_ack) begin
                    r_req <= 1'b0;
                    if (!w_drop) begin
                        r_load_data  <= w_ext;
                        r_load_valid <= ~r_we;
                    end
                end else if (w_timeout) begin
                    r_req <= 1'b0;
                    if (!w_drop) begin
                        r_bus_err   <= 1'b1;
                        r_load_data <= '0;
                    end
                end
            end
            if ((r_state == S_DONE) && stage_en) begin
                r_load_valid <= 1'b0;
                r_bus_err    <= 1'b0;
            end
        end
    end

    assign dm.dm_req   = r_req;
    assign dm.dm_we    = r_we;
    assign dm.dm_addr  = r_addr;
    assign dm.dm_be    = r_be;
    assign dm.dm_wdata = r_wdata;

    assign load_data  = r_load_data;
    assign load_valid = r_load_valid;
    assign bus_err    = r_bus_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, hand-written
// reset/idle sequences and randomized accesses checked against a reference model.
module tb_mem_access_unit;

    localparam int TMO = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [1:0]  mem_ctrl;
    logic [1:0]  mem_op;
    logic        mem_uns;
    logic        flush;
    logic        stage_en;
    logic        mem_stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        adel;
    logic        ades;
    logic        bus_err;

    mem_access_unit_if bus ();

    mem_access_unit #(.TIMEOUT(TMO), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_ctrl  (mem_ctrl),
        .mem_op    (mem_op),
        .mem_uns   (mem_uns),
        .flush     (flush),
        .stage_en  (stage_en),
        .dm        (bus),
        .mem_stall (mem_stall),
        .load_data (load_data),
        .load_valid(load_valid),
        .adel      (adel),
        .ades      (ades),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    // ack_at/flush_at: WAIT-cycle index (0 = first cycle dm_req is high), -1 = never.
    // e_stall: total cycles mem_stall is high (0 = no access issued).
    typedef struct {
        logic [1:0]  ctrl;
        logic [1:0]  op;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] rdata;
        int          ack_at;
        int          flush_at;
        logic        flush0;
        logic        e_adel;
        logic        e_ades;
        logic        e_we;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] e_ld;
        logic        e_valid;
        logic        e_err;
        int          e_stall;
    } vec_t;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: access size in bytes, byte offset and shifts.
    function automatic vec_t model(input logic [1:0] ctrl, input logic [1:0] op, input logic uns,
                                   input logic [31:0] addr, input logic [31:0] data,
                                   input logic [31:0] rdata, input int ack_at,
                                   input int flush_at, input logic flush0);
        vec_t v;
        int size, off, nwait;
        logic ld, st, al, tout, drop;
        logic [31:0] raw, mask;
        v.ctrl = ctrl; v.op = op; v.uns = uns; v.addr = addr; v.data = data;
        v.rdata = rdata; v.ack_at = ack_at; v.flush_at = flush_at; v.flush0 = flush0;
        size = (op == 2'd0) ? 4 : (op == 2'd1) ? 2 : 1;
        off  = int'(addr % 4);
        al   = (off % size) == 0;
        ld   = (ctrl == 2'd2);
        st   = (ctrl == 2'd1);
        v.e_adel = ld && !al && !flush0;
        v.e_ades = st && !al && !flush0;
        v.e_we   = st;
        v.e_be   = 4'(((1 << size) - 1) << off);
        for (int i = 0; i < 4; i++) v.e_wdata[8*i +: 8] = data[8*(i % size) +: 8];
        tout = 1'b0;
        drop = 1'b0;
        v.e_stall = 0;
        if ((ld || st) && al && !flush0) begin
            tout  = !(ack_at >= 0 && ack_at <= TMO);
            nwait = tout ? TMO + 1 : ack_at + 1;
            drop  = flush_at >= 0 && flush_at < nwait;
            v.e_stall = 1 + nwait;
        end
        raw  = rdata >> (8 * off);
        mask = (size == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * size)) - 32'd1;
        v.e_ld = raw & mask;
        if (!uns && size < 4 && raw[8*size-1]) v.e_ld = v.e_ld | ~mask;
        if (tout) v.e_ld = '0;
        v.e_valid = ld && (v.e_stall > 0) && !tout && !drop;
        v.e_err   = (v.e_stall > 0) && tout && !drop;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int nwait, stalls, hold;
        logic issued, drop;
        logic [31:0] ld_seen;
        issued = v.e_stall > 0;
        nwait  = issued ? v.e_stall - 1 : 0;
        drop   = issued && v.flush_at >= 0 && v.flush_at < nwait;
        stalls = 0;
        @(negedge clk);
        mem_addr = v.addr; mem_data = v.data; mem_ctrl = v.ctrl; mem_op = v.op;
        mem_uns = v.uns; flush = v.flush0; stage_en = 1'b0; bus.dm_ack = 1'b0;
        #1;
        chk({tag, ".adel"}, 32'(adel), 32'(v.e_adel));
        chk({tag, ".ades"}, 32'(ades), 32'(v.e_ades));
        chk({tag, ".req_issue"}, 32'(bus.dm_req), 32'd0);
        if (mem_stall) stalls++;
        if (!issued) begin
            @(negedge clk);
            mem_ctrl = 2'b00; flush = 1'b0;
            #1;
            chk({tag, ".req_none"}, 32'(bus.dm_req), 32'd0);
            chk({tag, ".stalls"}, 32'(stalls), 32'(v.e_stall));
            return;
        end
        for (int k = 0; k < nwait; k++) begin
            @(negedge clk);
            bus.dm_ack   = (k == v.ack_at);
            bus.dm_rdata = (k == v.ack_at) ? v.rdata : $urandom;
            flush        = (k == v.flush_at);
            stage_en     = 1'($urandom_range(0, 1));
            #1;
            if (mem_stall) stalls++;
            if (k == 0 || k == nwait - 1) begin
                chk({tag, $sformatf(".req_w%0d", k)}, 32'(bus.dm_req), 32'd1);
                chk({tag, ".addr"}, bus.dm_addr, v.addr & 32'hFFFF_FFFC);
                chk({tag, ".be"}, 32'(bus.dm_be), 32'(v.e_be));
                chk({tag, ".we"}, 32'(bus.dm_we), 32'(v.e_we));
                if (v.e_we) chk({tag, ".wdata"}, bus.dm_wdata, v.e_wdata);
            end
        end
        @(negedge clk);
        bus.dm_ack = 1'b0; flush = 1'b0; stage_en = 1'b0;
        if (drop) mem_ctrl = 2'b00;
        #1;
        if (mem_stall) stalls++;
        chk({tag, ".stalls"}, 32'(stalls), 32'(v.e_stall));
        chk({tag, ".req_end"}, 32'(bus.dm_req), 32'd0);
        chk({tag, ".valid"}, 32'(load_valid), 32'(v.e_valid));
        chk({tag, ".bus_err"}, 32'(bus_err), 32'(v.e_err));
        if (v.e_valid || v.e_err) chk({tag, ".load_data"}, load_data, v.e_ld);
        if (drop) return;
        ld_seen = load_data;
        hold = $urandom_range(0, 2);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            #1;
            chk({tag, ".hold_valid"}, 32'(load_valid), 32'(v.e_valid));
            chk({tag, ".hold_data"}, load_data, ld_seen);
            chk({tag, ".hold_noreissue"}, 32'(bus.dm_req | mem_stall), 32'd0);
        end
        @(negedge clk);
        stage_en = 1'b1;
        @(negedge clk);
        stage_en = 1'b0; mem_ctrl = 2'b00;
        #1;
        chk({tag, ".clr_valid"}, 32'(load_valid), 32'd0);
        chk({tag, ".clr_err"}, 32'(bus_err), 32'd0);
    endtask

    vec_t tbl[17];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t v;
        logic [1:0] rc;
        int ack, fl;
        // ctrl op uns addr data rdata ack flush flush0 | adel ades we be wdata ld valid err stall
        tbl[0]  = '{2'b10, 2'b00, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1, -1, 1'b0,
                    1'b0, 1'b0, 1'b0, 4'hF, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0, 3};
        tbl[1]  = '{2'b10, 2'b10, 1'b0, 32'h103, 32'h0, 32'h80123456, 0, -1, 1'b0,
                    1'b0, 1'b0, 1'b0, 4'h8, 32'h0, 32'hFFFFFF80, 1'b1, 1'b0, 2};
        tbl[2]  = '{2'b10, 2'b10, 1'b1, 32'h103, 32'h0, 32'h80123456, 0, -1, 1'b0,
                    1'b0, 1'b0, 1'b0, 4'h8, 32'h0, 32'h00000080, 1'b1, 1'b0, 2};
        tbl[3]  = '{2'b01, 2'b01, 1'b0, 32'h102, 32'h1234, 32'h0, 0, -1, 1'b0,
                    1'b0, 1'b0, 1'b1, 4'hC, 32'h12341234, 32'h0, 1'b0, 1'b0, 2};
        tbl[4]  = '{2'b10, 2'b00, 1'b0, 32'h101, 32'h0, 32'h0, 0, -1, 1'b0,
                    1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 0};
        tbl[5]  = '{2'b10, 2'b00, 1'b0, 32'h104, 32'h0, 32'h0, -1, -1, 1'b0,
                    1'b0, 1'b0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0, 1'b1, 14};
        tbl[6]  = '{2'b10, 2'b00, 1'b0, 32'h108, 32'h0, 32'h11111111, 3, 1, 1'b0,
                    1'b0, 1'b0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0, 1'b0, 5};
        tbl[7]  = '{2'b01, 2'b01, 1'b0, 32'h103, 32'h5555, 32'h0, 0, -1, 1'b0,
                    1'b0, 1'b1, 1'b1, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 0};
        tbl[8]  = '{2'b01, 2'b10, 1'b0, 32'h101, 32'hAB, 32'h0, 2, -1, 1'b0,
                    1'b0, 1'b0, 1'b1, 4'h2, 32'hABABABAB, 32'h0, 1'b0, 1'b0, 4};
        tbl[9]  = '{2'b10, 2'b01, 1'b0, 32'h102, 32'h0, 32'h9ABC0000, 0, -1, 1'b0,
                    1'b0, 1'b0, 1'b0, 4'hC, 32'h0, 32'hFFFF9ABC, 1'b1, 1'b0, 2};
        tbl[10] = '{2'b10, 2'b00, 1'b0, 32'h10C, 32'h0, 32'hCAFEF00D, 12, -1, 1'b0,
                    1'b0, 1'b0, 1'b0, 4'hF, 32'h0, 32'hCAFEF00D, 1'b1, 1'b0, 14};
        tbl[11] = '{2'b10, 2'b00, 1'b0, 32'h110, 32'h0, 32'h0, 0, -1, 1'b1,
                    1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 0};
        tbl[12] = '{2'b11, 2'b00, 1'b0, 32'h114, 32'h0, 32'h0, 0, -1, 1'b0,
                    1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 0};
        tbl[13] = '{2'b01, 2'b00, 1'b0, 32'h118, 32'h89ABCDEF, 32'h0, 0, -1, 1'b0,
                    1'b0, 1'b0, 1'b1, 4'hF, 32'h89ABCDEF, 32'h0, 1'b0, 1'b0, 2};
        tbl[14] = '{2'b01, 2'b10, 1'b0, 32'h11B, 32'h5A, 32'h0, -1, -1, 1'b0,
                    1'b0, 1'b0, 1'b1, 4'h8, 32'h5A5A5A5A, 32'h0, 1'b0, 1'b1, 14};
        tbl[15] = '{2'b10, 2'b00, 1'b0, 32'h120, 32'h0, 32'h12345678, 2, 2, 1'b0,
                    1'b0, 1'b0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0, 1'b0, 4};
        tbl[16] = '{2'b01, 2'b00, 1'b0, 32'h124, 32'h77, 32'h0, -1, 12, 1'b0,
                    1'b0, 1'b0, 1'b1, 4'hF, 32'h77, 32'h0, 1'b0, 1'b0, 14};

        rst = 1'b0; mem_addr = '0; mem_data = '0; mem_ctrl = 2'b00; mem_op = 2'b00;
        mem_uns = 1'b0; flush = 1'b0; stage_en = 1'b0;
        bus.dm_ack = 1'b0; bus.dm_rdata = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset.req", 32'(bus.dm_req), 32'd0);
        chk("reset.stall", 32'(mem_stall), 32'd0);
        chk("reset.valid", 32'(load_valid), 32'd0);
        chk("reset.bus_err", 32'(bus_err), 32'd0);
        chk("reset.load_data", load_data, 32'd0);
        chk("reset.be", 32'(bus.dm_be), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 17; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

        // Stray ack while idle must not produce a load result.
        @(negedge clk);
        bus.dm_ack = 1'b1; bus.dm_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.dm_ack = 1'b0;
        #1;
        chk("idle_ack.valid", 32'(load_valid), 32'd0);
        chk("idle_ack.req", 32'(bus.dm_req), 32'd0);

        // Asynchronous reset while a request is outstanding.
        @(negedge clk);
        mem_addr = 32'h200; mem_ctrl = 2'b10; mem_op = 2'b00;
        @(negedge clk);
        #1;
        chk("rst_wait.req_before", 32'(bus.dm_req), 32'd1);
        mem_ctrl = 2'b00;
        #1;
        rst = 1'b0;
        #1;
        chk("rst_wait.req_after", 32'(bus.dm_req), 32'd0);
        chk("rst_wait.stall", 32'(mem_stall), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        run_vec(tbl[5], "post_rst_timeout");

        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 9))
                0:       rc = 2'b00;
                1:       rc = 2'b11;
                2, 3, 4: rc = 2'b01;
                default: rc = 2'b10;
            endcase
            ack = ($urandom_range(0, 9) == 0) ? -1 :
                  ($urandom_range(0, 9) == 0) ? TMO : int'($urandom_range(0, 4));
            fl  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 5)) : -1;
            v = model(rc, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom,
                      $urandom, $urandom, ack, fl, ($urandom_range(0, 15) == 0));
            run_vec(v, $sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
